hazard_fwd_unit: RTL and testbench

- Owns pipeline hazard control for the 5-stage MIPS core.
- Drives the decode stage's `busA_select`/`busB_select` forwarding selects and its `write` (advance) and `flush` (squash) controls.
- Keeps a shadow scoreboard of destination registers in EX, MEM and WB, advanced in lockstep with the pipeline.
- Inserts load-use bubbles, honours memory back-pressure, squashes on exceptions and taken branches, and counts stall cycles.

---
 rtl/hazard_fwd_unit_if.sv | 34 +++
 rtl/hazard_fwd_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_if.sv
// Decode-stage hazard bus: operand/destination info from decode and the
// forwarding selects plus advance/squash controls returned by the hazard unit.
interface hazard_fwd_unit_if #(
  parameter int REGW = 5,
  parameter int CNTW = 32
);
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_reg_write;
  logic [REGW-1:0] id_reg_num;
  logic            id_mem_to_reg;
  logic            mem_busy;
  logic            branch_taken;
  logic            except;
  logic [1:0]      busA_select;
  logic [1:0]      busB_select;
  logic            write;
  logic            flush;
  logic [CNTW-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_reg_num,
           id_mem_to_reg, mem_busy, branch_taken, except,
    input  busA_select, busB_select, write, flush, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_reg_num,
           id_mem_to_reg, mem_busy, branch_taken, except,
    output busA_select, busB_select, write, flush, stall_count
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding control for the 5-stage core: shadow EX/MEM/WB
// destination scoreboard, operand forwarding selects, load-use bubbles, stall counter.
module hazard_fwd_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_unit_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] wnum;
    logic            is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wnum: {REGW{1'b0}}, is_load: 1'b0};

  slot_t           r_ex;
  slot_t           r_mem;
  slot_t           r_wb;
  logic [CNTW-1:0] r_stall_count;

  slot_t           w_ex_next;
  logic            w_load_use;
  logic            w_write;
  logic            w_flush;
  logic [1:0]      w_sel_a;
  logic [1:0]      w_sel_b;

  // Valid slots never hold r0, but the source check keeps r0 out regardless.
  function automatic logic src_hit(input slot_t s, input logic use_f,
                                   input logic [REGW-1:0] src);
    return use_f && (src != {REGW{1'b0}}) && s.valid && (s.wnum == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_f, input logic [REGW-1:0] src,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    logic [1:0] sel;
    if (src_hit(ex, use_f, src)) begin
      sel = 2'd1;
    end else if (src_hit(mem, use_f, src)) begin
      sel = 2'd2;
    end else if (src_hit(wb, use_f, src)) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Load in EX whose result a decode operand needs this cycle.
  always_comb begin
    w_load_use = r_ex.valid && r_ex.is_load &&
                 (src_hit(r_ex, bus.id_use_rs, bus.id_rs) ||
                  src_hit(r_ex, bus.id_use_rt, bus.id_rt));
  end

  // Advance/squash decision; reset forces a held, squashed pipeline.
  always_comb begin
    w_write = 1'b1;
    w_flush = 1'b0;
    if (!rst) begin
      w_write = 1'b0;
      w_flush = 1'b1;
    end else if (bus.except) begin
      w_write = 1'b1;
      w_flush = 1'b1;
    end else if (bus.mem_busy) begin
      w_write = 1'b0;
      w_flush = 1'b0;
    end else if (bus.branch_taken) begin
      w_write = 1'b1;
      w_flush = 1'b1;
    end else if (w_load_use) begin
      w_write = 1'b0;
      w_flush = 1'b1;
    end else begin
      w_write = 1'b1;
      w_flush = 1'b0;
    end
  end

  // Forwarding selects; forced to regfile while reset is asserted.
  always_comb begin
    w_sel_a = 2'd0;
    w_sel_b = 2'd0;
    if (!rst) begin
      w_sel_a = 2'd0;
      w_sel_b = 2'd0;
    end else begin
      w_sel_a = fwd_sel(bus.id_use_rs, bus.id_rs, r_ex, r_mem, r_wb);
      w_sel_b = fwd_sel(bus.id_use_rt, bus.id_rt, r_ex, r_mem, r_wb);
    end
  end

  // Entry for the EX slot: only an instruction that really advances, unsquashed, to a nonzero register.
  always_comb begin
    w_ex_next.valid   = bus.id_reg_write && w_write && !w_flush &&
                        (bus.id_reg_num != {REGW{1'b0}});
    w_ex_next.wnum    = bus.id_reg_num;
    w_ex_next.is_load = bus.id_mem_to_reg;
  end

  // Scoreboard advances in lockstep with the pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex  <= SLOT_EMPTY;
      r_mem <= SLOT_EMPTY;
      r_wb  <= SLOT_EMPTY;
    end else if (bus.except) begin
      r_ex  <= SLOT_EMPTY;
      r_mem <= SLOT_EMPTY;
      r_wb  <= SLOT_EMPTY;
    end else if (bus.mem_busy) begin
      r_ex  <= r_ex;
      r_mem <= r_mem;
      r_wb  <= r_wb;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
    end
  end

  // Saturating count of cycles in which decode did not advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= {CNTW{1'b0}};
    end else if (!w_write && (r_stall_count != {CNTW{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign bus.busA_select = w_sel_a;
  assign bus.busB_select = w_sel_b;
  assign bus.write       = w_write;
  assign bus.flush       = w_flush;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: per-cycle vector table through a
// scoreboard queue, plus reset-mid-stall and counter-saturation sequences.
module tb_hazard_fwd_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  hazard_fwd_unit_if #(.REGW(5), .CNTW(32)) b1 ();
  hazard_fwd_unit_if #(.REGW(5), .CNTW(2))  b2 ();

  hazard_fwd_unit #(.REGW(5), .CNTW(32)) dut (.clk(clk), .rst(rst), .bus(b1));
  hazard_fwd_unit #(.REGW(5), .CNTW(2))  dut_sat (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       rw;
    logic [4:0] rn;
    logic       ld;
    logic       busy;
    logic       br;
    logic       ex;
    logic       chk_sel;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       ew;
    logic       ef;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string nm, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                              logic rw, logic [4:0] rn, logic ld, logic busy, logic br, logic ex,
                              logic cs, logic [1:0] ea, logic [1:0] eb, logic ew, logic ef);
    vec_t v;
    v.name = nm; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.rw = rw; v.rn = rn; v.ld = ld; v.busy = busy; v.br = br; v.ex = ex;
    v.chk_sel = cs; v.ea = ea; v.eb = eb; v.ew = ew; v.ef = ef;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    b1.id_rs = v.rs;   b1.id_use_rs = v.urs;
    b1.id_rt = v.rt;   b1.id_use_rt = v.urt;
    b1.id_reg_write = v.rw; b1.id_reg_num = v.rn; b1.id_mem_to_reg = v.ld;
    b1.mem_busy = v.busy; b1.branch_taken = v.br; b1.except = v.ex;
  endtask

  task automatic drive_idle();
    drive(mk("idle", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd0, 1'b1, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;

    //           name          rs    urs   rt    urt   rw    rn    ld    busy  br    ex    cs    ea    eb    ew    ef
    vecs.push_back(mk("alu_wr_r3",  5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("alu_fwd_ex", 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("alu_fwd_mem",5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("alu_fwd_wb", 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("alu_fwd_no", 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("lw_r5",      5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("lu_stall",   5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk("lu_fwd_mem", 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk("lu_idle",    5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("pri_wr_r7a", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("pri_wr_r7b", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("pri_wr_r7c", 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("pri_ex",     5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0));
    vecs.push_back(mk("pri_mem",    5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("pri_wb",     5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("r0_load",    5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("r0_read",    5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("bp_wr_r4",   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("bp_idle",    5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk($sformatf("bp_busy%0d", k), 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                        1'b1, 2'd2, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("bp_rel_mem", 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("bp_rel_wb",  5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("ex_lw_r6",   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("ex_vs_lu",   5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk("ex_after",   5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("br_wr_r9",   5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("br_taken",   5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10,1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk("br_fwd_mem", 5'd9, 1'b1, 5'd10,1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("br_fwd_wb",  5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk("busy_vs_br", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0));

    // Reset state, checked with no clock edge seen yet.
    rst = 1'b0;
    drive_idle();
    b2.id_rs = 5'd0; b2.id_use_rs = 1'b0; b2.id_rt = 5'd0; b2.id_use_rt = 1'b0;
    b2.id_reg_write = 1'b0; b2.id_reg_num = 5'd0; b2.id_mem_to_reg = 1'b0;
    b2.mem_busy = 1'b0; b2.branch_taken = 1'b0; b2.except = 1'b0;
    #2;
    chk("rst_sel_a", {30'd0, b1.busA_select}, 32'd0);
    chk("rst_sel_b", {30'd0, b1.busB_select}, 32'd0);
    chk("rst_write", {31'd0, b1.write}, 32'd0);
    chk("rst_flush", {31'd0, b1.flush}, 32'd1);
    chk("rst_stall", b1.stall_count, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      if (e.chk_sel) begin
        chk({e.name, "_sel_a"}, {30'd0, b1.busA_select}, {30'd0, e.ea});
        chk({e.name, "_sel_b"}, {30'd0, b1.busB_select}, {30'd0, e.eb});
      end
      chk({e.name, "_write"}, {31'd0, b1.write}, {31'd0, e.ew});
      chk({e.name, "_flush"}, {31'd0, b1.flush}, {31'd0, e.ef});
      chk({e.name, "_stall"}, b1.stall_count, exp_cnt);
      if (!e.ew) exp_cnt++;
    end

    // Reset dropped mid-stall with valid slots: outputs go to reset values without a clock.
    @(posedge clk); #1;
    drive_idle(); b1.id_reg_write = 1'b1; b1.id_reg_num = 5'd8;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    drive_idle(); b1.id_rs = 5'd8; b1.id_use_rs = 1'b1; b1.mem_busy = 1'b1;
    @(negedge clk);
    chk("rmid_pre_sel_a", {30'd0, b1.busA_select}, 32'd2);
    chk("rmid_pre_write", {31'd0, b1.write}, 32'd0);
    chk("rmid_pre_stall", b1.stall_count, exp_cnt);
    @(posedge clk); #2;
    chk("rmid_stall_inc", b1.stall_count, exp_cnt + 1);
    rst = 1'b0;
    #1;
    chk("rmid_sel_a", {30'd0, b1.busA_select}, 32'd0);
    chk("rmid_write", {31'd0, b1.write}, 32'd0);
    chk("rmid_flush", {31'd0, b1.flush}, 32'd1);
    chk("rmid_stall", b1.stall_count, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    b1.mem_busy = 1'b0;
    #1;
    chk("rrel_sel_a", {30'd0, b1.busA_select}, 32'd0);
    chk("rrel_write", {31'd0, b1.write}, 32'd1);
    chk("rrel_flush", {31'd0, b1.flush}, 32'd0);
    @(negedge clk);
    chk("rrel_stall", b1.stall_count, 32'd0);

    // Narrow counter instance: must stick at all-ones.
    @(posedge clk); #1;
    b2.mem_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_cnt2", {30'd0, b2.stall_count}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", {30'd0, b2.stall_count}, 32'd3);
    chk("sat_write", {31'd0, b2.write}, 32'd0);
    b2.mem_busy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
